// File: rtl/machine_timer_if.sv
// Peripheral-bus request/response bundle for the machine timer.
// The master drives requests; the slave (the timer) returns one response per accepted request.
interface machine_timer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/machine_timer.sv
// Memory-mapped 64-bit mtime/mtimecmp timer with tear-free HI reads and a level interrupt.
// Optional 16-bit tick prescaler at offset 0x10 when MACHINE_TIMER_PRESCALER_EN is defined.
module machine_timer #(
  parameter logic [63:0] RESET_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  machine_timer_if.slave     bus,
  output logic               timer_interrupt_request,
  output logic [63:0]        mtime_out
);

  localparam logic [2:0] W_MTIME_LO    = 3'd0;
  localparam logic [2:0] W_MTIME_HI    = 3'd1;
  localparam logic [2:0] W_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] W_MTIMECMP_HI = 3'd3;
`ifdef MACHINE_TIMER_PRESCALER_EN
  localparam logic [2:0] W_PRESC       = 3'd4;
`endif

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  be
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic [31:0] hi_shadow_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_error_r;
  logic        irq_r;

  logic [2:0]  word_s;
  logic        mapped_s;
  logic        legal_s;
  logic        wr_s;
  logic        rd_s;
  logic        wr_mtime_lo_s;
  logic        wr_mtime_hi_s;
  logic        wr_cmp_lo_s;
  logic        wr_cmp_hi_s;
  logic        rd_mtime_lo_s;
  logic        tick_s;
  logic [31:0] rdata_s;
  logic [63:0] mtime_next_s;
  logic [63:0] mtimecmp_next_s;

`ifdef MACHINE_TIMER_PRESCALER_EN
  logic [15:0] presc_r;
  logic [15:0] presc_cnt_r;
  logic        wr_presc_s;
  logic [31:0] presc_merged_s;
`endif

  // Address decode and request qualification
  always_comb begin
    word_s   = bus.req_addr[4:2];
    mapped_s = 1'b0;
    case (word_s)
      W_MTIME_LO, W_MTIME_HI, W_MTIMECMP_LO, W_MTIMECMP_HI: mapped_s = 1'b1;
`ifdef MACHINE_TIMER_PRESCALER_EN
      W_PRESC: mapped_s = 1'b1;
`endif
      default: mapped_s = 1'b0;
    endcase
    legal_s       = (bus.req_addr[1:0] == 2'b00) && mapped_s;
    wr_s          = bus.req_valid && bus.req_write && legal_s;
    rd_s          = bus.req_valid && !bus.req_write && legal_s;
    wr_mtime_lo_s = wr_s && (word_s == W_MTIME_LO);
    wr_mtime_hi_s = wr_s && (word_s == W_MTIME_HI);
    wr_cmp_lo_s   = wr_s && (word_s == W_MTIMECMP_LO);
    wr_cmp_hi_s   = wr_s && (word_s == W_MTIMECMP_HI);
    rd_mtime_lo_s = rd_s && (word_s == W_MTIME_LO);
  end

  // Read data mux; MTIME_HI returns the shadow captured by the last LO read
  always_comb begin
    rdata_s = 32'd0;
    case (word_s)
      W_MTIME_LO:    rdata_s = mtime_r[31:0];
      W_MTIME_HI:    rdata_s = hi_shadow_r;
      W_MTIMECMP_LO: rdata_s = mtimecmp_r[31:0];
      W_MTIMECMP_HI: rdata_s = mtimecmp_r[63:32];
`ifdef MACHINE_TIMER_PRESCALER_EN
      W_PRESC:       rdata_s = {16'd0, presc_r};
`endif
      default:       rdata_s = 32'd0;
    endcase
  end

`ifdef MACHINE_TIMER_PRESCALER_EN
  // Prescaler tick: fires when the count reaches PRESC, suppressed on a PRESC write
  always_comb begin
    wr_presc_s     = wr_s && (word_s == W_PRESC);
    presc_merged_s = merge_bytes({16'd0, presc_r}, bus.req_wdata, {2'b00, bus.req_be[1:0]});
    if (wr_presc_s) begin
      tick_s = 1'b0;
    end else begin
      tick_s = (presc_cnt_r == presc_r);
    end
  end

  // Prescaler register and count
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r     <= 16'd0;
      presc_cnt_r <= 16'd0;
    end else if (wr_presc_s) begin
      presc_r     <= presc_merged_s[15:0];
      presc_cnt_r <= 16'd0;
    end else if (presc_cnt_r == presc_r) begin
      presc_cnt_r <= 16'd0;
    end else begin
      presc_cnt_r <= presc_cnt_r + 16'd1;
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // Next mtime: a write to either half stores exactly and suppresses the tick
  always_comb begin
    mtime_next_s = mtime_r;
    if (wr_mtime_lo_s) begin
      mtime_next_s = {mtime_r[63:32], merge_bytes(mtime_r[31:0], bus.req_wdata, bus.req_be)};
    end else if (wr_mtime_hi_s) begin
      mtime_next_s = {merge_bytes(mtime_r[63:32], bus.req_wdata, bus.req_be), mtime_r[31:0]};
    end else if (tick_s) begin
      mtime_next_s = mtime_r + 64'd1;
    end else begin
      mtime_next_s = mtime_r;
    end
  end

  // Next mtimecmp from byte-merged writes
  always_comb begin
    mtimecmp_next_s = mtimecmp_r;
    if (wr_cmp_lo_s) begin
      mtimecmp_next_s = {mtimecmp_r[63:32], merge_bytes(mtimecmp_r[31:0], bus.req_wdata, bus.req_be)};
    end else if (wr_cmp_hi_s) begin
      mtimecmp_next_s = {merge_bytes(mtimecmp_r[63:32], bus.req_wdata, bus.req_be), mtimecmp_r[31:0]};
    end else begin
      mtimecmp_next_s = mtimecmp_r;
    end
  end

  // Timer state, shadow and interrupt level
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_r     <= 64'd0;
      mtimecmp_r  <= RESET_MTIMECMP;
      hi_shadow_r <= 32'd0;
      irq_r       <= 1'b0;
    end else begin
      mtime_r    <= mtime_next_s;
      mtimecmp_r <= mtimecmp_next_s;
      irq_r      <= (mtime_r >= mtimecmp_r);
      if (rd_mtime_lo_s) begin
        hi_shadow_r <= mtime_r[63:32];
      end else begin
        hi_shadow_r <= hi_shadow_r;
      end
    end
  end

  // One-deep response register
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_error_r <= 1'b0;
    end else begin
      resp_valid_r <= bus.req_valid;
      resp_rdata_r <= rd_s ? rdata_s : 32'd0;
      resp_error_r <= bus.req_valid && !legal_s;
    end
  end

  assign bus.req_ready           = 1'b1;
  assign bus.resp_valid          = resp_valid_r;
  assign bus.resp_rdata          = resp_rdata_r;
  assign bus.resp_error          = resp_error_r;
  assign timer_interrupt_request = irq_r;
  assign mtime_out               = mtime_r;

endmodule

// File: tb/tb_machine_timer.sv
// Directed-vector bench for machine_timer with a transaction-level reference model
// checked every cycle, plus literal expectations taken from hand-worked scenarios.
module tb_machine_timer;

`ifdef MACHINE_TIMER_PRESCALER_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        irq;
  logic [63:0] mtime_out;
  int          checks;
  int          failures;
  logic        chk_en;
  logic [31:0] last_rdata;
  logic        last_err;
  logic        last_valid;

  machine_timer_if bus();

  machine_timer dut (
    .clk                     (clk),
    .rst                     (rst),
    .bus                     (bus),
    .timer_interrupt_request (irq),
    .mtime_out               (mtime_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic [31:0] shadow;
    logic [15:0] presc;
    logic [15:0] cnt;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        irq;
  } mstate_t;

  localparam mstate_t RESET_STATE = '{mtime: 64'd0, cmp: 64'hFFFF_FFFF_FFFF_FFFF,
                                      shadow: 32'd0, presc: 16'd0, cnt: 16'd0,
                                      rv: 1'b0, rd: 32'd0, re: 1'b0, irq: 1'b0};

  mstate_t m;

  // Reference: one bus cycle of the timer, described from the register-map rules
  function automatic mstate_t step(input mstate_t s, input logic valid, input logic write,
                                   input logic [4:0] addr, input logic [31:0] wd,
                                   input logic [3:0] be);
    mstate_t     n;
    int          w;
    bit          legal;
    bit          tick;
    bit          mwrite;
    logic [31:0] mask;
    n      = s;
    w      = int'(addr) / 4;
    legal  = (int'(addr) % 4 == 0) && (w < 4 || (PEN && w == 4));
    tick   = PEN ? (s.cnt == s.presc) : 1'b1;
    mwrite = 1'b0;
    mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    n.rv   = valid;
    n.rd   = 32'd0;
    n.re   = valid && !legal;
    n.irq  = (s.mtime >= s.cmp);
    if (PEN) n.cnt = (s.cnt == s.presc) ? 16'd0 : s.cnt + 16'd1;
    if (valid && legal && !write) begin
      case (w)
        0: begin n.rd = s.mtime[31:0]; n.shadow = s.mtime[63:32]; end
        1: n.rd = s.shadow;
        2: n.rd = s.cmp[31:0];
        3: n.rd = s.cmp[63:32];
        4: n.rd = {16'd0, s.presc};
        default: n.rd = 32'd0;
      endcase
    end
    if (valid && legal && write) begin
      case (w)
        0: begin n.mtime[31:0]  = (s.mtime[31:0]  & ~mask) | (wd & mask); mwrite = 1'b1; end
        1: begin n.mtime[63:32] = (s.mtime[63:32] & ~mask) | (wd & mask); mwrite = 1'b1; end
        2: n.cmp[31:0]  = (s.cmp[31:0]  & ~mask) | (wd & mask);
        3: n.cmp[63:32] = (s.cmp[63:32] & ~mask) | (wd & mask);
        4: begin
          n.presc[7:0]  = be[0] ? wd[7:0]  : s.presc[7:0];
          n.presc[15:8] = be[1] ? wd[15:8] : s.presc[15:8];
          n.cnt = 16'd0;
          tick  = 1'b0;
        end
        default: ;
      endcase
    end
    if (!mwrite && tick) n.mtime = s.mtime + 64'd1;
    return n;
  endfunction

  always @(posedge clk) begin
    m <= rst ? RESET_STATE : step(m, bus.req_valid, bus.req_write, bus.req_addr, bus.req_wdata, bus.req_be);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_resp_valid", {63'd0, bus.resp_valid}, {63'd0, m.rv});
      if (m.rv) begin
        check("model_resp_rdata", {32'd0, bus.resp_rdata}, {32'd0, m.rd});
        check("model_resp_error", {63'd0, bus.resp_error}, {63'd0, m.re});
      end
      check("model_irq", {63'd0, irq}, {63'd0, m.irq});
      check("model_mtime", mtime_out, m.mtime);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic wr, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    last_rdata    = bus.resp_rdata;
    last_err      = bus.resp_error;
    last_valid    = bus.resp_valid;
  endtask

  initial begin
    int          n;
    logic [63:0] m0;
    checks        = 0;
    failures      = 0;
    chk_en        = 1'b0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 5'd0;
    bus.req_wdata = 32'd0;
    bus.req_be    = 4'd0;

    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    check("reset_mtime", mtime_out, 64'd0);
    check("reset_irq", {63'd0, irq}, 64'd0);
    check("reset_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    rst = 1'b0;

    cyc(10);
    xfer(1'b0, 5'h00, 32'd0, 4'hF);
    check("read_lo_after_10", {32'd0, last_rdata}, 64'd10);
    check("read_lo_valid", {63'd0, last_valid}, 64'd1);
    check("irq_idle", {63'd0, irq}, 64'd0);

    xfer(1'b1, 5'h0C, 32'd0, 4'hF);
    xfer(1'b1, 5'h08, 32'd20, 4'hF);
    n = 0;
    while (mtime_out != 64'd20 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_mtime_20", {63'd0, (n < 50)}, 64'd1);
    check("irq_not_yet", {63'd0, irq}, 64'd0);
    cyc(1);
    check("irq_rise", {63'd0, irq}, 64'd1);
    xfer(1'b1, 5'h08, 32'hFFFF_FFFF, 4'hF);
    check("irq_held_one_cycle", {63'd0, irq}, 64'd1);
    cyc(1);
    check("irq_fall", {63'd0, irq}, 64'd0);

    xfer(1'b1, 5'h00, 32'hFFFF_FFFE, 4'hF);
    xfer(1'b1, 5'h04, 32'd5, 4'hF);
    check("mtime_written", mtime_out, 64'h0000_0005_FFFF_FFFE);
    cyc(2);
    xfer(1'b0, 5'h00, 32'd0, 4'hF);
    check("carry_lo", {32'd0, last_rdata}, 64'd0);
    xfer(1'b0, 5'h04, 32'd0, 4'hF);
    check("carry_hi_shadow", {32'd0, last_rdata}, 64'd6);
    xfer(1'b1, 5'h04, 32'd9, 4'hF);
    cyc(3);
    xfer(1'b0, 5'h04, 32'd0, 4'hF);
    check("hi_shadow_holds", {32'd0, last_rdata}, 64'd6);

    xfer(1'b1, 5'h00, 32'hAABB_CCDD, 4'hF);
    xfer(1'b1, 5'h00, 32'h0000_1234, 4'b0011);
    check("partial_write_lo", mtime_out, 64'h0000_0009_AABB_1234);

    xfer(1'b0, 5'h02, 32'd0, 4'hF);
    check("misaligned_err", {63'd0, last_err}, 64'd1);
    check("misaligned_rdata", {32'd0, last_rdata}, 64'd0);
    xfer(1'b0, 5'h14, 32'd0, 4'hF);
    check("unmapped_err", {63'd0, last_err}, 64'd1);
    xfer(1'b0, 5'h10, 32'd0, 4'hF);
    check("presc_off_err", {63'd0, last_err}, PEN ? 64'd0 : 64'd1);
    check("presc_off_rdata", {32'd0, last_rdata}, 64'd0);
    xfer(1'b1, 5'h06, 32'h5555_5555, 4'hF);
    check("err_write_err", {63'd0, last_err}, 64'd1);

    xfer(1'b1, 5'h00, 32'hFFFF_FFFF, 4'hF);
    xfer(1'b1, 5'h04, 32'hFFFF_FFFF, 4'hF);
    check("all_ones", mtime_out, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(1);
    check("wrap_to_zero", mtime_out, 64'd0);

    if (PEN) begin
      xfer(1'b1, 5'h10, 32'hFFFF_0003, 4'b0011);
      m0 = mtime_out;
      cyc(8);
      check("presc_rate", mtime_out, m0 + 64'd2);
      xfer(1'b0, 5'h10, 32'd0, 4'hF);
      check("presc_read", {32'd0, last_rdata}, 64'd3);
    end

    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 5'h00;
    rst           = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("midrst_mtime", mtime_out, 64'd0);
    check("midrst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("midrst_irq", {63'd0, irq}, 64'd0);
    rst = 1'b0;
    xfer(1'b0, 5'h04, 32'd0, 4'hF);
    check("midrst_shadow", {32'd0, last_rdata}, 64'd0);
    xfer(1'b0, 5'h08, 32'd0, 4'hF);
    check("midrst_cmp_lo", {32'd0, last_rdata}, 64'hFFFF_FFFF);
    if (PEN) begin
      xfer(1'b0, 5'h10, 32'd0, 4'hF);
      check("midrst_presc", {32'd0, last_rdata}, 64'd0);
    end
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped machine timer that keeps the 64-bit `mtime` counter and the `mtimecmp` compare value. It drives `timer_interrupt_request` into the control/status register file, which gates it with `mstatus.MIE` and `mie.MTIE`. It sits on the core's peripheral bus beside the data memory port. It also exports the live counter for `rdtime`/`rdtimeh`.

## Interface
- `RESET_MTIMECMP`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`. No interrupt out of reset.
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  1  bus request present this cycle
- `req_ready`  out  1  always 1; every request accepted the cycle it is valid
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  5  byte offset within timer block
- `req_wdata`  in  32  write data
- `req_be`  in  4  write byte enables; ignored on reads
- `resp_valid`  out  1  response strobe, exactly one cycle after each accepted request
- `resp_rdata`  out  32  read data, valid with `resp_valid`; 0 for writes and errors
- `resp_error`  out  1  decode/alignment error, valid with `resp_valid`
- `timer_interrupt_request`  out  1  registered level: `mtime >= mtimecmp`
- `mtime_out`  out  64  current `mtime` register value

## Operation
- Register map (word offsets):
  - 0x00 `MTIME_LO`
  - 0x04 `MTIME_HI`
  - 0x08 `MTIMECMP_LO`
  - 0x0C `MTIMECMP_HI`
  - 0x10 `PRESC` (only with the macro)
- Error conditions: `req_addr[1:0] != 0`, or offset unmapped. Response: `resp_error`=1 and `resp_rdata`=0; writes have no effect.
- Writes: merged per byte with `req_be`. Bytes with `be`=0 keep their old value.
- Counter: 64-bit unsigned `mtime`, +1 per tick with carry from LO into HI. Wraps from all-ones to 0.
- Write/tick collision: a write to `MTIME_LO` or `MTIME_HI` suppresses the tick increment in that cycle. The written value is stored exactly; the other half holds.
- Tear-free 64-bit read:
  - A read of `MTIME_LO` returns the current LO and latches the current HI into `hi_shadow` in the same cycle.
  - A read of `MTIME_HI` returns `hi_shadow`, not live HI.
  - `hi_shadow` reset value is 0.
- Compare: unsigned 64-bit `mtime >= mtimecmp`, evaluated on current register values each cycle and registered into `timer_interrupt_request`.
- Level semantics: the request stays asserted until software raises `mtimecmp` or lowers `mtime`. It is not a pulse.
- No internal state machine beyond the one-deep response register and the prescaler counter. Back-to-back requests every cycle are supported.

## Timing
- Reset values:
  - `mtime` = 0, `mtimecmp` = `RESET_MTIMECMP`, `hi_shadow` = 0
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_error` = 0
  - `timer_interrupt_request` = 0
  - `PRESC` = 0, prescaler count = 0
- Reset has priority over any request in the same cycle. A request accepted in the cycle `rst` is high produces no response.
- Read latency 1: request at cycle N, then `resp_valid`/`resp_rdata`/`resp_error` at cycle N+1. Data is the register value at cycle N, before N's updates.
- Write effect: visible in the registers at N+1. A read at N+1 returns the new value at N+2.
- Interrupt latency:
  - Compare becomes true at register state of cycle N, so `timer_interrupt_request`=1 at N+1.
  - Clearing by writing `mtimecmp` at N lowers the request at N+2.
- `mtime_out` is the register output and carries no extra delay.

## Configuration
- `MACHINE_TIMER_PRESCALER_EN` defined:
  - 16-bit `PRESC` at 0x10, R/W, only `be[1:0]` significant. Upper read bits are 0.
  - Prescale counter counts 0..`PRESC`. A tick occurs when count == `PRESC`, then the count returns to 0. `mtime` therefore advances every `PRESC`+1 cycles.
  - Writing `PRESC` clears the count, and no tick occurs that cycle.
- Not defined: tick every cycle, no prescaler logic. Offset 0x10 is unmapped and returns `resp_error`.

## Test plan
- Reset, then idle 10 cycles, then read 0x00 -> `resp_rdata`=10 one cycle after the request; `timer_interrupt_request`=0.
- Write `MTIMECMP_HI`=0, then `MTIMECMP_LO`=20 -> `timer_interrupt_request` rises on the cycle after `mtime` reaches 20. Then write `MTIMECMP_LO`=0xFFFF_FFFF -> request falls two cycles after that write.
- Write `MTIME_LO`=0xFFFF_FFFE, `MTIME_HI`=5 -> after 2 ticks, read LO = 0 and read HI = 6. A HI read alone after a further LO change returns the shadow value latched by the last LO read.
- Write `MTIME_LO`=0x1234 with `be`=4'b0011 while the counter is running -> LO[15:0]=0x1234, upper bytes keep their old value, and no increment occurs that cycle.
- Read 0x02 and 0x14 -> `resp_error`=1, `resp_rdata`=0. Offset 0x10 errors only without `MACHINE_TIMER_PRESCALER_EN`.
- With the macro, write `PRESC`=3 -> `mtime` increments once per 4 cycles. Assert `rst` mid-run -> all registers return to their reset values on the next edge.
